uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period, minimum 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  input  1  serial line, asynchronous to clk, idles high.
REQ-006 out_data  output  DATASIZE  received byte, LSB received first.
REQ-007 out_valid  output  1  out_data holds an unconsumed byte.
REQ-008 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse, parity mismatch; tied 0 when parity is compiled out.
REQ-011 overrun  output  1  one-cycle pulse, byte dropped because the holding register was full.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 rx_i SHALL pass a 2-flop synchronizer; all decisions use the synchronized value, adding 2 cycles of latency.
REQ-014 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on a synchronized high-to-low transition; the bit counter clears.
REQ-016 START SHALL resample at cycle CLKS_PER_BIT/2; if low -> DATA; if high -> IDLE (false start, no output, no error).
REQ-017 DATA SHALL sample each bit CLKS_PER_BIT cycles after the previous sample, DATASIZE samples, shifting LSB first.
REQ-018 After the last data bit, the FSM SHALL go to PARITY when parity is enabled, else to STOP.
REQ-019 STOP SHALL sample at mid-bit: high -> byte complete; low -> frame_err pulse, byte discarded.
REQ-020 After a low stop bit, the FSM SHALL stay in STOP until synchronized rx is high, then go to IDLE (break handling).
REQ-021 On completion, out_data/out_valid SHALL update on the cycle after the stop sample.
REQ-022 If the holding register is empty, or is emptied by the handshake in that same cycle, the new byte SHALL load and overrun SHALL stay 0.
REQ-023 If out_valid && !out_ready at completion, the held byte SHALL be kept, the new byte dropped, and overrun pulsed.
REQ-024 out_valid SHALL clear on the cycle after an accepted handshake unless a new byte loads in that cycle.
REQ-025 out_data SHALL stay stable while out_valid is high and not accepted.
REQ-026 Counters SHALL be sized $clog2(CLKS_PER_BIT) and $clog2(DATASIZE+1) bits, with no wrap inside a frame.

Reset
REQ-027 On rst_n low, the FSM SHALL go to IDLE and synchronizer flops SHALL go to 1.
REQ-028 Reset SHALL set out_data=0, out_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial byte; after release, reception resumes only on the next falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: add the PARITY state and parameter PARITY_ODD (default 0 = even); sample at mid-bit; on mismatch pulse parity_err, discard the byte, and still process STOP.
REQ-031 UART_RX_PARITY_EN undefined: no PARITY state, parity_err constant 0, frame = start + DATASIZE + stop.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and the default DATASIZE/CLKS_PER_BIT constants, shared with uart_tx and the test benches.
REQ-033 The synchronizer SHALL be sub-module uart_sync (2-flop, reset value 1); everything else is inline.

Verification (CLKS_PER_BIT=16, DATASIZE=8)
REQ-034 Frame 0xA5, out_ready=1 -> out_valid for 1 cycle with out_data=0xA5, about 154 clks after the start edge; no error pulses.
REQ-035 rx_i low for 4 clks, then high -> busy returns to 0, no out_valid, no errors.
REQ-036 Frame 0x3C with stop bit 0 held low 40 clks -> one frame_err pulse, no out_valid, busy until rx high.
REQ-037 Frames 0x11 then 0x22 with out_ready=0 -> out_data=0x11 held, one overrun pulse; then out_ready=1 -> 0x11 accepted, out_valid drops.
REQ-038 UART_RX_PARITY_EN, even parity, 0x01 sent with parity bit 0 -> one parity_err pulse, no out_valid; with parity bit 1 -> 0x01 delivered.
REQ-039 rst_n pulsed low during bit 4 of 0xFF -> all outputs 0; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default frame geometry.
package uart_pkg;

  localparam int DEF_DATASIZE     = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments so q takes meta's previous value, giving two real stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with a one-entry holding register and valid/ready handshake.
// Optional parity checking is compiled in by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATASIZE     = DEF_DATASIZE,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_i,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATASIZE + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATASIZE - 1);

  uart_state_e         state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DATASIZE-1:0] shift;
  logic                rx_s;
  logic                rx_prev;
  logic                brk;
`ifdef UART_RX_PARITY_EN
  logic                par_bad;
`else
  assign parity_err = 1'b0;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  // NOTE: the shift register is reset along with the rest so no stale bits leak after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_prev   <= 1'b1;
      brk       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      rx_prev <= rx_s;
      cnt     <= cnt + 1'b1;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) begin
            state   <= START;
            bit_cnt <= '0;
            brk     <= 1'b0;
            busy    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATASIZE-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= STOP;
            if ((^shift ^ rx_s) != PARITY_ODD) begin
              parity_err <= 1'b1;
              par_bad    <= 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (brk) begin
            // Line held low past the stop bit: wait out the break before re-arming.
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              brk   <= 1'b0;
            end
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
`else
              begin
`endif
                if (!out_valid || out_ready) begin
                  out_data  <= shift;
                  out_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, corner sequences and random frames vs a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DS  = DEF_DATASIZE;
  localparam int CPB = DEF_CLKS_PER_BIT;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_i = 1'b1;
  logic          out_ready = 1'b1;
  logic [DS-1:0] out_data;
  logic          out_valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(.DATASIZE(DS), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: counts pulses and records every accepted byte.
  int            cyc = 0;
  int            n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
  int            valid_rise_cyc = 0;
  logic          prev_v = 1'b0;
  logic [DS-1:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (overrun)    n_ovr++;
      if (out_valid)  n_vcyc++;
      if (out_valid && !prev_v) valid_rise_cyc = cyc;
      if (out_valid && out_ready) got.push_back(out_data);
      prev_v = out_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  int start_cyc;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    idle(n);
  endtask

  task automatic send_body(input logic [DS-1:0] d, input logic flip_par);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DS; i++) drive_bit(d[i], CPB);
    if (PAR_EN) drive_bit((^d) ^ flip_par, CPB);
  endtask

  task automatic send_frame(input logic [DS-1:0] d, input logic stop, input logic flip_par);
    send_body(d, flip_par);
    drive_bit(stop, CPB);
    rx_i = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      idle(1);
      k++;
    end
    check({name, "_idle"}, busy, 1'b0);
    idle(4);
  endtask

  typedef struct {
    logic [DS-1:0] data;
    logic          stop;
    int            exp_bytes;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  int            s_b, s_f, s_p, s_o, s_v, lat;
  logic [DS-1:0] exp_q[$];
  int            exp_ferr, exp_perr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};

    // Reset state
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    idle(4);

    // Single 0xA5 frame: latency and one-cycle valid
    s_b = got.size(); s_f = n_ferr; s_p = n_perr; s_o = n_ovr; s_v = n_vcyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_idle("a5");
    lat = valid_rise_cyc - start_cyc;
    check("a5_bytes", got.size() - s_b, 1);
    if (got.size() > s_b) check("a5_data", got[$], 8'hA5);
    check("a5_valid_cycles", n_vcyc - s_v, 1);
    check("a5_latency_window", (lat >= 150 && lat <= 160), 1);
    check("a5_no_errs", (n_ferr - s_f) + (n_perr - s_p) + (n_ovr - s_o), 0);

    // Directed table
    foreach (vecs[i]) begin
      s_b = got.size(); s_f = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_bytes", i), got.size() - s_b, vecs[i].exp_bytes);
      check($sformatf("vec%0d_ferr", i), n_ferr - s_f, vecs[i].exp_ferr);
      if (vecs[i].exp_bytes == 1 && got.size() > s_b)
        check($sformatf("vec%0d_data", i), got[$], vecs[i].data);
    end

    // False start
    s_b = got.size(); s_f = n_ferr; s_v = n_vcyc;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2);
    check("fs_busy_during", busy, 1);
    wait_idle("fs");
    check("fs_no_valid", n_vcyc - s_v, 0);
    check("fs_no_ferr", n_ferr - s_f, 0);

    // Break: stop bit held low 40 clocks
    s_b = got.size(); s_f = n_ferr; s_v = n_vcyc;
    send_body(8'h3C, 1'b0);
    drive_bit(1'b0, 40);
    check("brk_busy_low", busy, 1);
    check("brk_ferr", n_ferr - s_f, 1);
    rx_i = 1'b1;
    wait_idle("brk");
    check("brk_no_valid", n_vcyc - s_v, 0);

    // Overrun with consumer stalled
    s_b = got.size(); s_o = n_ovr;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_idle("ovr");
    check("ovr_valid_held", out_valid, 1);
    check("ovr_data_held", out_data, 8'h11);
    check("ovr_pulses", n_ovr - s_o, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("ovr_valid_drop", out_valid, 0);
    check("ovr_accepted_cnt", got.size() - s_b, 1);
    if (got.size() > s_b) check("ovr_accepted_data", got[$], 8'h11);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x01 needs parity bit 1 (even)
    s_b = got.size(); s_p = n_perr;
    send_frame(8'h01, 1'b1, 1'b1);
    wait_idle("par_bad");
    check("par_bad_perr", n_perr - s_p, 1);
    check("par_bad_bytes", got.size() - s_b, 0);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_idle("par_good");
    check("par_good_perr", n_perr - s_p, 1);
    check("par_good_bytes", got.size() - s_b, 1);
    if (got.size() > s_b) check("par_good_data", got[$], 8'h01);
`endif

    // Random frames vs frame-level model
    s_b = got.size(); s_f = n_ferr; s_p = n_perr;
    exp_q.delete();
    exp_ferr = 0; exp_perr = 0;
    for (int n = 0; n < 24; n++) begin
      logic [DS-1:0] d;
      logic          stop, flip;
      d    = DS'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      flip = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, flip);
      if (flip) exp_perr++;
      if (!stop) exp_ferr++;
      else if (!flip) exp_q.push_back(d);
      idle($urandom_range(2, 20));
    end
    wait_idle("rnd");
    check("rnd_count", got.size() - s_b, exp_q.size());
    check("rnd_ferr", n_ferr - s_f, exp_ferr);
    check("rnd_perr", n_perr - s_p, exp_perr);
    for (int i = 0; i < exp_q.size(); i++)
      if (s_b + i < got.size())
        check($sformatf("rnd_data%0d", i), got[s_b + i], exp_q[i]);

    // Reset during bit 4 of 0xFF, then a clean 0x5A
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB / 2);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    idle(2);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    idle(4 * CPB);
    check("mid_post_rst_idle", busy, 0);
    s_b = got.size(); s_f = n_ferr;
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_idle("post_rst");
    check("post_rst_bytes", got.size() - s_b, 1);
    if (got.size() > s_b) check("post_rst_data", got[$], 8'h5A);
    check("post_rst_ferr", n_ferr - s_f, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
